// File: rtl/alu_retry_if.sv
// Host-side request/response bundle for alu_retry_controller.
// The master issues ops and consumes responses; the slave is the controller.
interface alu_retry_if #(
  parameter int DATA_W    = 16,
  parameter int MAX_RETRY = 3
);
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);

  logic               in_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  in_a;
  logic [DATA_W-1:0]  in_b;
  logic [3:0]         in_op;

  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  out_result;
  logic               out_cout;
  logic               out_zero;
  logic               out_overflow;
  logic               out_fail;
  logic [RETRY_W-1:0] out_retries;

  modport master (
    output in_valid, in_a, in_b, in_op, out_ready,
    input  in_ready, out_valid, out_result, out_cout, out_zero, out_overflow,
           out_fail, out_retries
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, out_ready,
    output in_ready, out_valid, out_result, out_cout, out_zero, out_overflow,
           out_fail, out_retries
  );
endinterface

// File: rtl/alu_retry_controller.sv
// Front-end for a fault-checked ALU: issues one op at a time, samples the
// result ALU_LAT edges later and re-issues (after a one-cycle ZERO flush)
// whenever any checker fires, up to MAX_RETRY times. Keeps fault statistics.
module alu_retry_controller #(
  parameter int DATA_W    = 16,
  parameter int ALU_LAT   = 2,
  parameter int MAX_RETRY = 3,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst,
  alu_retry_if.slave        host,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              alu_cout,
  input  logic              alu_zero,
  input  logic              alu_overflow,
  input  logic              alu_parity_err,
  input  logic              alu_residue3_err,
  input  logic              alu_residue5_err,
  input  logic              alu_carry_err,
  input  logic              alu_error,
  output logic [CNT_W-1:0]  cnt_detect,
  output logic [CNT_W-1:0]  cnt_fail,
  output logic [3:0]        err_sticky,
  input  logic              clr_stats
);
  localparam int RETRY_W = $clog2(MAX_RETRY + 1);
  localparam int WAIT_W  = $clog2(ALU_LAT + 1);
  localparam logic [3:0] OP_ZERO = 4'b1011;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FLUSH, S_RESP} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [3:0]          alu_op_q, alu_op_d, op_save_q, op_save_d;
  logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
  logic [RETRY_W-1:0]  retries_q, retries_d;
  logic [DATA_W-1:0]   out_result_q, out_result_d;
  logic                out_cout_q, out_cout_d, out_zero_q, out_zero_d;
  logic                out_ovf_q, out_ovf_d, out_fail_q, out_fail_d;
  logic [CNT_W-1:0]    cnt_detect_q, cnt_detect_d, cnt_fail_q, cnt_fail_d;
  logic [3:0]          err_sticky_q, err_sticky_d;

  logic err, sample, fail_evt;

  assign err    = alu_error | alu_parity_err | alu_residue3_err |
                  alu_residue5_err | alu_carry_err;
  assign sample = (state_q == S_WAIT) && (wait_cnt_q == WAIT_W'(1));

  // Next-state, datapath and statistics update
  always_comb begin
    state_d      = state_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    op_save_d    = op_save_q;
    wait_cnt_d   = wait_cnt_q;
    retries_d    = retries_q;
    out_result_d = out_result_q;
    out_cout_d   = out_cout_q;
    out_zero_d   = out_zero_q;
    out_ovf_d    = out_ovf_q;
    out_fail_d   = out_fail_q;
    cnt_detect_d = cnt_detect_q;
    cnt_fail_d   = cnt_fail_q;
    err_sticky_d = err_sticky_q;
    fail_evt     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (host.in_valid) begin
          alu_a_d    = host.in_a;
          alu_b_d    = host.in_b;
          alu_op_d   = host.in_op;
          op_save_d  = host.in_op;
          wait_cnt_d = WAIT_W'(ALU_LAT);
          retries_d  = '0;
          state_d    = S_WAIT;
        end
      end
      S_WAIT: begin
        if (sample) begin
          out_result_d = alu_result;
          out_cout_d   = alu_cout;
          out_zero_d   = alu_zero;
          out_ovf_d    = alu_overflow;
          if (!err) begin
            out_fail_d = 1'b0;
            state_d    = S_RESP;
          end else if (retries_q < RETRY_W'(MAX_RETRY)) begin
            retries_d = retries_q + RETRY_W'(1);
            alu_op_d  = OP_ZERO;
            state_d   = S_FLUSH;
          end else begin
            out_fail_d = 1'b1;
            fail_evt   = 1'b1;
            state_d    = S_RESP;
          end
        end else begin
          wait_cnt_d = wait_cnt_q - WAIT_W'(1);
        end
      end
      S_FLUSH: begin
        // operands stayed put through the flush; only the opcode comes back
        alu_op_d   = op_save_q;
        wait_cnt_d = WAIT_W'(ALU_LAT);
        state_d    = S_WAIT;
      end
      S_RESP: begin
        if (host.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (sample && err) begin
      if (cnt_detect_q != '1) cnt_detect_d = cnt_detect_q + CNT_W'(1);
      // alu_error has no sticky bit of its own
      err_sticky_d = err_sticky_q |
                     {alu_carry_err, alu_residue5_err, alu_residue3_err, alu_parity_err};
    end
    if (fail_evt && (cnt_fail_q != '1)) cnt_fail_d = cnt_fail_q + CNT_W'(1);

    // a clear beats any increment landing on the same edge
    if (clr_stats) begin
      cnt_detect_d = '0;
      cnt_fail_d   = '0;
      err_sticky_d = '0;
    end
  end

  // State and datapath registers, synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= OP_ZERO;
      op_save_q    <= OP_ZERO;
      wait_cnt_q   <= '0;
      retries_q    <= '0;
      out_result_q <= '0;
      out_cout_q   <= 1'b0;
      out_zero_q   <= 1'b0;
      out_ovf_q    <= 1'b0;
      out_fail_q   <= 1'b0;
      cnt_detect_q <= '0;
      cnt_fail_q   <= '0;
      err_sticky_q <= '0;
    end else begin
      state_q      <= state_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      op_save_q    <= op_save_d;
      wait_cnt_q   <= wait_cnt_d;
      retries_q    <= retries_d;
      out_result_q <= out_result_d;
      out_cout_q   <= out_cout_d;
      out_zero_q   <= out_zero_d;
      out_ovf_q    <= out_ovf_d;
      out_fail_q   <= out_fail_d;
      cnt_detect_q <= cnt_detect_d;
      cnt_fail_q   <= cnt_fail_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  assign host.in_ready     = (state_q == S_IDLE) && !rst;
  assign host.out_valid    = (state_q == S_RESP);
  assign host.out_result   = out_result_q;
  assign host.out_cout     = out_cout_q;
  assign host.out_zero     = out_zero_q;
  assign host.out_overflow = out_ovf_q;
  assign host.out_fail     = out_fail_q;
  assign host.out_retries  = retries_q;

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign cnt_detect = cnt_detect_q;
  assign cnt_fail   = cnt_fail_q;
  assign err_sticky = err_sticky_q;
endmodule
